usermem_responder: RTL
======================

USERMEM_RESPONDER -- requirements
Module: usermem_responder

Interface
REQ-001 SHALL have parameter: IO_BASE, 8'hF0, first I/O register address; addresses below it are RAM.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: usermem_address  input  8  CPU byte address.
REQ-005 SHALL have port: usermem_data_out  input  8  CPU write data.
REQ-006 SHALL have port: rw  input  1  1 = write, 0 = read.
REQ-007 SHALL have port: usermem_data_in  output  8  read data returned to CPU.
REQ-008 SHALL have port: interrupt  output  1  timer interrupt request to CPU.
REQ-009 SHALL have port: gpio_in  input  8  asynchronous external inputs.
REQ-010 SHALL have port: gpio_out  output  8  registered external outputs.

Function
REQ-011 SHALL decode address < IO_BASE as RAM (IO_BASE bytes, 8-bit wide); address >= IO_BASE as I/O.
REQ-012 SHALL return read data combinationally from usermem_address, zero wait states, regardless of rw.
REQ-013 SHALL commit writes on the rising clk edge when rw=1; rw=0 SHALL never alter state.
REQ-014 SHALL map I/O: +0 RELOAD (RW), +1 COUNT (RO), +2 CTRL (RW; bit0 EN, bit1 IRQ_EN, bit2 AUTO, bits7:3 read 0), +3 STATUS (bit0 PEND, write-1-to-clear), +4 GPIO_OUT (RW), +5 GPIO_IN (RO), +6 PRESCALE (RW).
REQ-015 SHALL read 0x00 from +7..+15 and ignore writes there and to RO registers.
REQ-016 SHALL load both RELOAD and COUNT on a write to RELOAD; this write wins over a same-cycle tick.
REQ-017 SHALL run an 8-bit prescale counter while EN=1, producing a one-cycle tick when it equals PRESCALE, then restarting at 0.
REQ-018 SHALL clear the prescale counter on any CTRL write that changes EN from 0 to 1.
REQ-019 SHALL, on a tick with COUNT > 1, decrement COUNT by 1.
REQ-020 SHALL, on a tick with COUNT <= 1 (expiry), set PEND; if AUTO=1 load COUNT from RELOAD, else set COUNT=0 and clear EN.
REQ-021 SHALL give set priority: expiry in the same cycle as a PEND write-1-to-clear leaves PEND=1.
REQ-022 SHALL drive interrupt = PEND AND IRQ_EN from registered state (glitch-free), asserted the cycle after the expiring edge.
REQ-023 SHALL synchronize gpio_in through two flops; GPIO_IN reads the second stage.
REQ-024 SHALL drive gpio_out directly from the GPIO_OUT register.

Reset
REQ-025 SHALL, on reset assertion, immediately clear RELOAD, COUNT, CTRL, PEND, PRESCALE, prescale counter, GPIO_OUT and sync flops to 0, giving interrupt=0 and gpio_out=0x00 without waiting for clk.
REQ-026 SHALL NOT reset RAM contents; RAM reads before first write are undefined.
REQ-027 SHALL abort any in-progress count on reset mid-operation; no expiry may occur while reset is high.

Structure
REQ-028 SHALL place I/O register offsets, CTRL/STATUS bit positions and the default IO_BASE in a shared package used by this block and the CPU control unit.
REQ-029 SHALL implement prescaler, COUNT and expiry logic in one sub-module, usermem_timer; decode, RAM, GPIO and read mux stay in the top.

Verification
REQ-030 SHALL cover RAM: write 0x5A to 0x10, then read 0x10 -> 0x5A; read with rw=0 over 10 cycles -> value unchanged.
REQ-031 SHALL cover auto-reload: PRESCALE=0, RELOAD=3, CTRL=0x07 at edge E0 -> COUNT 2 at E1, 1 at E2, expiry at E3 (COUNT=3, interrupt high after E3); next expiry at E6.
REQ-032 SHALL cover one-shot: RELOAD=2, CTRL=0x03 -> one expiry, then COUNT=0, CTRL reads 0x02, no further PEND after clear.
REQ-033 SHALL cover collision: write 0x01 to STATUS on the expiry edge -> PEND remains 1, interrupt stays high.
REQ-034 SHALL cover GPIO: gpio_in=0xA5 -> GPIO_IN reads 0xA5 after two edges, not one; write 0x3C to GPIO_OUT -> gpio_out=0x3C after that edge.
REQ-035 SHALL cover reset mid-count: assert reset between edges with COUNT=5, PEND=1 -> interrupt=0, gpio_out=0x00, COUNT=0 before the next edge.

Source files
------------

// File: rtl/usermem_responder_pkg.sv
// Shared address map and control/status bit positions for the user-memory responder.
// The CPU control unit imports this package as well, so both sides decode the same offsets.
package usermem_responder_pkg;

  localparam logic [7:0] IO_BASE_DEFAULT = 8'hF0;

  localparam logic [7:0] OFF_RELOAD   = 8'd0;
  localparam logic [7:0] OFF_COUNT    = 8'd1;
  localparam logic [7:0] OFF_CTRL     = 8'd2;
  localparam logic [7:0] OFF_STATUS   = 8'd3;
  localparam logic [7:0] OFF_GPIO_OUT = 8'd4;
  localparam logic [7:0] OFF_GPIO_IN  = 8'd5;
  localparam logic [7:0] OFF_PRESCALE = 8'd6;

  localparam int CTRL_W      = 3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int STATUS_PEND = 0;

endpackage

// File: rtl/usermem_responder_if.sv
// CPU-side user-memory bus: byte address, write data, write strobe and combinational read data.
// Handshake: no valid/ready; rw=1 commits on the next rising clk edge, read data is always valid for the current address.
interface usermem_responder_if;
  logic [7:0] usermem_address;
  logic [7:0] usermem_data_out;
  logic       rw;
  logic [7:0] usermem_data_in;

  modport master (
    output usermem_address, usermem_data_out, rw,
    input  usermem_data_in
  );

  modport slave (
    input  usermem_address, usermem_data_out, rw,
    output usermem_data_in
  );
endinterface

// File: rtl/usermem_timer.sv
// Prescaled down-counter with reload, one-shot/auto-reload modes and a pending-interrupt flag.
// The top decodes addresses; this block only sees per-register write strobes.
module usermem_timer
  import usermem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wdata,
  input  logic              wr_reload,
  input  logic              wr_ctrl,
  input  logic              wr_status,
  input  logic              wr_prescale,
  output logic [7:0]        reload,
  output logic [7:0]        count,
  output logic [7:0]        prescale,
  output logic [CTRL_W-1:0] ctrl,
  output logic              pend,
  output logic              interrupt
);

  logic [7:0]        reload_q, reload_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        prescale_q, prescale_d;
  logic [7:0]        pcnt_q, pcnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pend_q, pend_d;
  logic              irq_q, irq_d;
  logic              en, tick, expire;

  always_comb begin
    en     = ctrl_q[CTRL_EN];
    tick   = en && (pcnt_q == prescale_q);
    // A RELOAD write consumes the tick, so it can never also expire.
    expire = tick && !wr_reload && (count_q <= 8'd1);

    pcnt_d = pcnt_q;
    if (en) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    if (wr_ctrl && !en && wdata[CTRL_EN]) pcnt_d = 8'd0;

    reload_d   = wr_reload ? wdata : reload_q;
    prescale_d = wr_prescale ? wdata : prescale_q;

    count_d = count_q;
    if (wr_reload)                count_d = wdata;
    else if (tick && !expire)     count_d = count_q - 8'd1;
    else if (expire)              count_d = ctrl_q[CTRL_AUTO] ? reload_q : 8'd0;

    ctrl_d = ctrl_q;
    if (expire && !ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl) ctrl_d = wdata[CTRL_W-1:0];

    // Set wins over a same-cycle write-1-to-clear.
    pend_d = (pend_q && !(wr_status && wdata[STATUS_PEND])) || expire;
    irq_d  = pend_d && ctrl_d[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q   <= 8'd0;
      count_q    <= 8'd0;
      prescale_q <= 8'd0;
      pcnt_q     <= 8'd0;
      ctrl_q     <= '0;
      pend_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      ctrl_q     <= ctrl_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
    end
  end

  assign reload    = reload_q;
  assign count     = count_q;
  assign prescale  = prescale_q;
  assign ctrl      = ctrl_q;
  assign pend      = pend_q;
  assign interrupt = irq_q;

endmodule

// File: rtl/usermem_responder.sv
// User-memory responder: RAM below IO_BASE, timer/GPIO registers above it, zero-wait-state reads.
// Address decode, RAM, GPIO and the read mux live here; the timer is in usermem_timer.
module usermem_responder
  import usermem_responder_pkg::*;
#(
  parameter logic [7:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] usermem_address,
  input  logic [7:0] usermem_data_out,
  input  logic       rw,
  output logic [7:0] usermem_data_in,
  output logic       interrupt,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  logic [7:0] ram_q [0:IO_BASE-1];

  logic [7:0]        io_off;
  logic              is_io, ram_we, io_we;
  logic              wr_reload, wr_ctrl, wr_status, wr_prescale, wr_gpio_out;
  logic [7:0]        gpio_sync1_q, gpio_sync1_d, gpio_sync2_q, gpio_sync2_d;
  logic [7:0]        gpio_out_q, gpio_out_d;
  logic [7:0]        t_reload, t_count, t_prescale;
  logic [CTRL_W-1:0] t_ctrl;
  logic              t_pend;

  always_comb begin
    is_io       = (usermem_address >= IO_BASE);
    io_off      = usermem_address - IO_BASE;
    ram_we      = rw && !is_io;
    io_we       = rw && is_io;
    wr_reload   = io_we && (io_off == OFF_RELOAD);
    wr_ctrl     = io_we && (io_off == OFF_CTRL);
    wr_status   = io_we && (io_off == OFF_STATUS);
    wr_gpio_out = io_we && (io_off == OFF_GPIO_OUT);
    wr_prescale = io_we && (io_off == OFF_PRESCALE);

    gpio_sync1_d = gpio_in;
    gpio_sync2_d = gpio_sync1_q;
    gpio_out_d   = wr_gpio_out ? usermem_data_out : gpio_out_q;
  end

  // RAM has no reset: contents survive a reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[usermem_address] <= usermem_data_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_sync1_q <= 8'd0;
      gpio_sync2_q <= 8'd0;
      gpio_out_q   <= 8'd0;
    end else begin
      gpio_sync1_q <= gpio_sync1_d;
      gpio_sync2_q <= gpio_sync2_d;
      gpio_out_q   <= gpio_out_d;
    end
  end

  usermem_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .wdata       (usermem_data_out),
    .wr_reload   (wr_reload),
    .wr_ctrl     (wr_ctrl),
    .wr_status   (wr_status),
    .wr_prescale (wr_prescale),
    .reload      (t_reload),
    .count       (t_count),
    .prescale    (t_prescale),
    .ctrl        (t_ctrl),
    .pend        (t_pend),
    .interrupt   (interrupt)
  );

  always_comb begin
    usermem_data_in = 8'd0;
    if (!is_io) begin
      usermem_data_in = ram_q[usermem_address];
    end else begin
      case (io_off)
        OFF_RELOAD:   usermem_data_in = t_reload;
        OFF_COUNT:    usermem_data_in = t_count;
        OFF_CTRL:     usermem_data_in = {{(8-CTRL_W){1'b0}}, t_ctrl};
        OFF_STATUS:   usermem_data_in = {7'd0, t_pend};
        OFF_GPIO_OUT: usermem_data_in = gpio_out_q;
        OFF_GPIO_IN:  usermem_data_in = gpio_sync2_q;
        OFF_PRESCALE: usermem_data_in = t_prescale;
        default:      usermem_data_in = 8'd0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;

endmodule
